// File: rtl/decoder.sv
// MIPS-subset instruction decoder: one-hot instruction flags, main control and
// hazard timing from op/func, plus an enable-gated registered control bundle.
module decoder #(
    parameter logic [1:0] T_ALU = 2'd1,
    parameter logic [1:0] T_DM  = 2'd2,
    parameter logic [1:0] T_PC  = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    output logic        addu,
    output logic        subu,
    output logic        ori,
    output logic        lui,
    output logic        lw,
    output logic        sw,
    output logic        beq,
    output logic        j,
    output logic        jal,
    output logic        jr,
    output logic        illegal,
    output logic        RegWr,
    output logic        MemWr,
    output logic [2:0]  ALUctr,
    output logic        ALUBE_sel,
    output logic        ExtOp,
    output logic [1:0]  RFWDW_sel,
    output logic [1:0]  A3_sel,
    output logic [1:0]  NPC_sel,
    output logic [1:0]  Tnew,
    output logic [1:0]  Tuse_rs,
    output logic [1:0]  Tuse_rt,
    output logic [19:0] ctrl_q
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [19:0] ctrl_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        addu    = 1'b0;
        subu    = 1'b0;
        ori     = 1'b0;
        lui     = 1'b0;
        lw      = 1'b0;
        sw      = 1'b0;
        beq     = 1'b0;
        j       = 1'b0;
        jal     = 1'b0;
        jr      = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADDU: addu    = 1'b1;
                    FN_SUBU: subu    = 1'b1;
                    FN_JR:   jr      = 1'b1;
                    FN_NOP:  ;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ORI:  ori     = 1'b1;
            OP_LUI:  lui     = 1'b1;
            OP_LW:   lw      = 1'b1;
            OP_SW:   sw      = 1'b1;
            OP_BEQ:  beq     = 1'b1;
            OP_J:    j       = 1'b1;
            OP_JAL:  jal     = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Nop and illegal encodings fall through with every control at zero.
    always_comb begin
        RegWr     = 1'b0;
        MemWr     = 1'b0;
        ALUctr    = 3'd0;
        ALUBE_sel = 1'b0;
        ExtOp     = 1'b0;
        RFWDW_sel = 2'd0;
        A3_sel    = 2'd0;
        NPC_sel   = 2'd0;
        Tnew      = T_PC;
        Tuse_rs   = 2'd0;
        Tuse_rt   = 2'd0;
        if (addu || subu) begin
            RegWr   = 1'b1;
            A3_sel  = 2'd1;
            ALUctr  = subu ? 3'd1 : 3'd0;
            Tnew    = T_ALU;
            Tuse_rs = 2'd1;
            Tuse_rt = 2'd1;
        end
        if (ori || lui) begin
            RegWr     = 1'b1;
            ALUctr    = lui ? 3'd3 : 3'd2;
            ALUBE_sel = 1'b1;
            Tnew      = T_ALU;
            Tuse_rs   = lui ? TUSE_NONE : 2'd1;
            Tuse_rt   = TUSE_NONE;
        end
        if (lw) begin
            RegWr     = 1'b1;
            ALUBE_sel = 1'b1;
            ExtOp     = 1'b1;
            RFWDW_sel = 2'd1;
            Tnew      = T_DM;
            Tuse_rs   = 2'd1;
            Tuse_rt   = TUSE_NONE;
        end
        if (sw) begin
            MemWr     = 1'b1;
            ALUBE_sel = 1'b1;
            ExtOp     = 1'b1;
            Tuse_rs   = 2'd1;
            Tuse_rt   = 2'd2;
        end
        if (beq) begin
            NPC_sel = 2'd1;
            ExtOp   = 1'b1;
        end
        if (j || jal) begin
            NPC_sel = 2'd2;
            Tuse_rs = TUSE_NONE;
            Tuse_rt = TUSE_NONE;
        end
        if (jal) begin
            RegWr     = 1'b1;
            A3_sel    = 2'd2;
            RFWDW_sel = 2'd2;
        end
        if (jr) begin
            NPC_sel = 2'd3;
            Tuse_rt = TUSE_NONE;
        end
    end

    assign ctrl_d = {RegWr, MemWr, ALUctr, ALUBE_sel, ExtOp, RFWDW_sel,
                     A3_sel, NPC_sel, Tnew, illegal, Tuse_rs, Tuse_rt};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset)
            ctrl_q <= 20'd0;
        else if (en)
            ctrl_q <= ctrl_d;
    end

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder: combinational decode of every
// encoding, nop/illegal handling, and the enable/reset behaviour of ctrl_q.
module tb_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        addu, subu, ori, lui, lw, sw, beq, j, jal, jr, illegal;
    logic        RegWr, MemWr, ALUBE_sel, ExtOp;
    logic [2:0]  ALUctr;
    logic [1:0]  RFWDW_sel, A3_sel, NPC_sel, Tnew, Tuse_rs, Tuse_rt;
    logic [19:0] ctrl_q;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [10:0] flags;
        logic [19:0] ctrl;
    } vec_t;

    // Expected bundles, packed {RegWr,MemWr,ALUctr,ALUBE_sel,ExtOp,RFWDW_sel,A3_sel,NPC_sel,Tnew,illegal,Tuse_rs,Tuse_rt}
    localparam logic [19:0] C_ADDU = 20'b1_0_000_0_0_00_01_00_01_0_01_01;
    localparam logic [19:0] C_SUBU = 20'b1_0_001_0_0_00_01_00_01_0_01_01;
    localparam logic [19:0] C_ORI  = 20'b1_0_010_1_0_00_00_00_01_0_01_11;
    localparam logic [19:0] C_LUI  = 20'b1_0_011_1_0_00_00_00_01_0_11_11;
    localparam logic [19:0] C_LW   = 20'b1_0_000_1_1_01_00_00_10_0_01_11;
    localparam logic [19:0] C_SW   = 20'b0_1_000_1_1_00_00_00_00_0_01_10;
    localparam logic [19:0] C_BEQ  = 20'b0_0_000_0_1_00_00_01_00_0_00_00;
    localparam logic [19:0] C_J    = 20'b0_0_000_0_0_00_00_10_00_0_11_11;
    localparam logic [19:0] C_JAL  = 20'b1_0_000_0_0_10_10_10_00_0_11_11;
    localparam logic [19:0] C_JR   = 20'b0_0_000_0_0_00_00_11_00_0_00_11;
    localparam logic [19:0] C_NOP  = 20'b0_0_000_0_0_00_00_00_00_0_00_00;
    localparam logic [19:0] C_ILL  = 20'b0_0_000_0_0_00_00_00_00_1_00_00;

    wire [10:0] obs_flags = {addu, subu, ori, lui, lw, sw, beq, j, jal, jr, illegal};
    wire [19:0] obs_ctrl  = {RegWr, MemWr, ALUctr, ALUBE_sel, ExtOp, RFWDW_sel,
                             A3_sel, NPC_sel, Tnew, illegal, Tuse_rs, Tuse_rt};

    decoder dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .func(func),
        .addu(addu), .subu(subu), .ori(ori), .lui(lui), .lw(lw), .sw(sw),
        .beq(beq), .j(j), .jal(jal), .jr(jr), .illegal(illegal),
        .RegWr(RegWr), .MemWr(MemWr), .ALUctr(ALUctr), .ALUBE_sel(ALUBE_sel),
        .ExtOp(ExtOp), .RFWDW_sel(RFWDW_sel), .A3_sel(A3_sel), .NPC_sel(NPC_sel),
        .Tnew(Tnew), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .ctrl_q(ctrl_q)
    );

    always #5 clk = ~clk;

    task automatic run_table(input vec_t tv[$]);
        foreach (tv[i]) begin
            op   = tv[i].op;
            func = tv[i].func;
            #1;
            checks++;
            if (obs_flags !== tv[i].flags) begin
                failures++;
                $display("FAIL %s flags: got %b expected %b", tv[i].name, obs_flags, tv[i].flags);
            end
            checks++;
            if (obs_ctrl !== tv[i].ctrl) begin
                failures++;
                $display("FAIL %s ctrl: got %b expected %b", tv[i].name, obs_ctrl, tv[i].ctrl);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        op    = 6'b001101;
        func  = 6'b000000;
        @(posedge clk);
        #1;
        checks++;
        if (ctrl_q !== 20'd0) begin
            failures++;
            $display("FAIL reset_ctrl_q: got %h expected %h", ctrl_q, 20'd0);
        end
        checks++;
        if (obs_ctrl !== C_ORI) begin
            failures++;
            $display("FAIL reset_comb_unaffected: got %b expected %b", obs_ctrl, C_ORI);
        end
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_alu;
        vec_t tv[$];
        tv.push_back('{"addu", 6'b000000, 6'b100001, 11'b10000000000, C_ADDU});
        tv.push_back('{"subu", 6'b000000, 6'b100011, 11'b01000000000, C_SUBU});
        tv.push_back('{"ori",  6'b001101, 6'b111111, 11'b00100000000, C_ORI});
        tv.push_back('{"lui",  6'b001111, 6'b000000, 11'b00010000000, C_LUI});
        run_table(tv);
    endtask

    task automatic test_mem;
        vec_t tv[$];
        tv.push_back('{"lw_func0",   6'b100011, 6'b000000, 11'b00001000000, C_LW});
        tv.push_back('{"lw_funcsub", 6'b100011, 6'b100011, 11'b00001000000, C_LW});
        tv.push_back('{"subu_alias", 6'b000000, 6'b100011, 11'b01000000000, C_SUBU});
        tv.push_back('{"sw",         6'b101011, 6'b101010, 11'b00000100000, C_SW});
        run_table(tv);
    endtask

    task automatic test_branch_jump;
        vec_t tv[$];
        tv.push_back('{"beq", 6'b000100, 6'b000000, 11'b00000010000, C_BEQ});
        tv.push_back('{"j",   6'b000010, 6'b001000, 11'b00000001000, C_J});
        tv.push_back('{"jal", 6'b000011, 6'b000000, 11'b00000000100, C_JAL});
        tv.push_back('{"jr",  6'b000000, 6'b001000, 11'b00000000010, C_JR});
        run_table(tv);
    endtask

    task automatic test_nop_illegal;
        vec_t tv[$];
        tv.push_back('{"nop",         6'b000000, 6'b000000, 11'b00000000000, C_NOP});
        tv.push_back('{"ill_op3f",    6'b111111, 6'b000000, 11'b00000000001, C_ILL});
        tv.push_back('{"ill_func3f",  6'b000000, 6'b111111, 11'b00000000001, C_ILL});
        tv.push_back('{"ill_addiu",   6'b001001, 6'b100001, 11'b00000000001, C_ILL});
        tv.push_back('{"ill_func20",  6'b000000, 6'b100000, 11'b00000000001, C_ILL});
        run_table(tv);
    endtask

    task automatic test_enable;
        @(negedge clk);
        en   = 1'b1;
        op   = 6'b001101;
        func = 6'b000000;
        @(posedge clk);
        #1;
        checks++;
        if (ctrl_q !== C_ORI) begin
            failures++;
            $display("FAIL en_load_ori: got %b expected %b", ctrl_q, C_ORI);
        end
        @(negedge clk);
        en = 1'b0;
        op = 6'b101011;
        @(posedge clk);
        #1;
        checks++;
        if (ctrl_q !== C_ORI) begin
            failures++;
            $display("FAIL en_hold: got %b expected %b", ctrl_q, C_ORI);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ctrl_q !== C_ORI) begin
            failures++;
            $display("FAIL en_hold_2: got %b expected %b", ctrl_q, C_ORI);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        en   = 1'b1;
        op   = 6'b000011;
        func = 6'b000000;
        @(negedge clk);
        checks++;
        if (ctrl_q !== C_JAL) begin
            failures++;
            $display("FAIL b2b_jal: got %b expected %b", ctrl_q, C_JAL);
        end
        op = 6'b100011;
        @(negedge clk);
        checks++;
        if (ctrl_q !== C_LW) begin
            failures++;
            $display("FAIL b2b_lw: got %b expected %b", ctrl_q, C_LW);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_priority;
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        op    = 6'b101011;
        func  = 6'b000000;
        @(posedge clk);
        #1;
        checks++;
        if (ctrl_q !== 20'd0) begin
            failures++;
            $display("FAIL reset_over_en: got %b expected %b", ctrl_q, 20'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ctrl_q !== C_SW) begin
            failures++;
            $display("FAIL post_reset_load: got %b expected %b", ctrl_q, C_SW);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        op    = 6'b000000;
        func  = 6'b000000;
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_nop_illegal();
        test_enable();
        test_back_to_back();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
